// File: rtl/writeback_stage.sv
// Final MIPS pipeline stage: registers execute results, completes loads, drives the RF write port and forwarding pair.
// Latency: ALU results write one cycle after capture; loads write in the cycle after DMemValid is sampled.
// Backpressure: Stall is held high while a captured load waits for data memory; nothing is captured while Stall=1.
module writeback_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ALUResult,
   input  logic [4:0]  RegDest,
   input  logic        RegWrite,
   input  logic        MemRead,
   input  logic [2:0]  LoadType,
   input  logic        Kill,
   input  logic [31:0] DMemDout,
   input  logic        DMemValid,
   output logic        Stall,
   output logic        RegFileWE,
   output logic [4:0]  RegFileWA,
   output logic [31:0] RegFileWD,
   output logic [4:0]  ForwardRA,
   output logic [31:0] ForwardRD
);

   // Load type encodings; unlisted codes fall back to a full-word load.
   localparam logic [2:0] LT_LW  = 3'd0;
   localparam logic [2:0] LT_LH  = 3'd1;
   localparam logic [2:0] LT_LHU = 3'd2;
   localparam logic [2:0] LT_LB  = 3'd3;
   localparam logic [2:0] LT_LBU = 3'd4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      LOAD_DONE = 2'd2
   } state_t;

   // Stage register contents for the instruction currently in writeback.
   typedef struct packed {
      logic        v;
      logic        rw;
      logic        ld;
      logic [2:0]  lt;
      logic [4:0]  dest;
      logic [31:0] res;
   } stage_t;

   state_t      state;
   stage_t      stage;
   logic [31:0] ldata;

   logic        stall;
   logic        capture;
   logic        new_load;
   logic        wr;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_val;
   logic [31:0] wd;

   // Stall depends only on the FSM state, so it never glitches with inputs.
   assign stall    = (state == LOAD_WAIT);
   assign capture  = ~stall;
   assign new_load = ~Kill & MemRead;

   // Big-endian byte/halfword extraction of the pending load's data word.
   always_comb begin
      byte_val = DMemDout[31:24];
      case (stage.res[1:0])
         2'd0:    byte_val = DMemDout[31:24];
         2'd1:    byte_val = DMemDout[23:16];
         2'd2:    byte_val = DMemDout[15:8];
         default: byte_val = DMemDout[7:0];
      endcase
      half_val = stage.res[1] ? DMemDout[15:0] : DMemDout[31:16];
      case (stage.lt)
         LT_LW:   load_val = DMemDout;
         LT_LH:   load_val = {{16{half_val[15]}}, half_val};
         LT_LHU:  load_val = {16'h0000, half_val};
         LT_LB:   load_val = {{24{byte_val[7]}}, byte_val};
         LT_LBU:  load_val = {24'h000000, byte_val};
         default: load_val = DMemDout;
      endcase
   end

   // Stage register: capture the incoming instruction (or a bubble) on non-stalled edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else if (capture) begin
         stage.v    <= ~Kill;
         stage.rw   <= RegWrite;
         stage.ld   <= MemRead;
         stage.lt   <= LoadType;
         stage.dest <= RegDest;
         stage.res  <= ALUResult;
      end
   end

   // Load FSM: wait for data memory, latch the extracted value, then write it back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ldata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (new_load) state <= LOAD_WAIT;
            end
            LOAD_WAIT: begin
               // DMemValid is only meaningful here; elsewhere it is ignored.
               if (DMemValid) begin
                  ldata <= load_val;
                  state <= LOAD_DONE;
               end
            end
            LOAD_DONE: begin
               // The finished load writes this cycle; a new load may be captured at this edge.
               state <= new_load ? LOAD_WAIT : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write qualification: loads only write once their data has arrived; $0 never writes.
   assign wr = stage.v & stage.rw & (stage.dest != 5'd0) & (~stage.ld | (state == LOAD_DONE));
   assign wd = stage.ld ? ldata : stage.res;

   assign Stall     = stall;
   assign RegFileWE = wr;
   assign RegFileWA = stage.dest;
   assign RegFileWD = wd;
   assign ForwardRA = wr ? stage.dest : 5'd0;
   assign ForwardRD = wr ? wd : 32'd0;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the MIPS datapath. Registers the execute-stage result, completes loads (waits on data memory, extracts and extends bytes/halfwords), and drives the register-file write port. Publishes the in-flight write as a forwarding pair (ForwardRA/ForwardRD), which the execute-stage operand selector compares against rs/rt. Stalls the upstream pipeline while a load is outstanding.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ALUResult  in  32  execute-stage result; load byte address when MemRead=1
- RegDest  in  5  destination register number
- RegWrite  in  1  instruction writes a register
- MemRead  in  1  instruction is a load
- LoadType  in  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu; other codes behave as lw
- Kill  in  1  capture a bubble instead of the incoming instruction
- DMemDout  in  32  data-memory read data, qualified by DMemValid
- DMemValid  in  1  DMemDout holds the pending load's word
- Stall  out  1  freeze upstream stages; no capture this edge
- RegFileWE  out  1  register-file write enable
- RegFileWA  out  5  register-file write address
- RegFileWD  out  32  register-file write data
- ForwardRA  out  5  register being written this cycle; 0 = none
- ForwardRD  out  32  value of ForwardRA; always 0 when ForwardRA=0

## Operation
- Stage register fields: V (valid), RW, LD, LT, DEST, RES.
- Capture at every rising edge with Stall=0: V = ~Kill; RW, LD, DEST, LT, and RES take RegWrite, MemRead, RegDest, LoadType, and ALUResult. While Stall=1, all fields hold.
- FSM states:
  - IDLE: no load pending.
    - If the edge captures V=1 and LD=1, go to LOAD_WAIT.
  - LOAD_WAIT: Stall=1.
    - If DMemValid=1 at the edge, latch the extracted load value into LDATA and go to LOAD_DONE.
    - Otherwise remain.
  - LOAD_DONE: load writes back this cycle; Stall=0.
    - Next state is LOAD_WAIT if a new load is captured at that edge, else IDLE.
- Load extraction is big-endian. Byte k of the word = DMemDout[31-8k -: 8], with k=RES[1:0].
  - lh/lhu: halfword at RES[1]=0 → [31:16], RES[1]=1 → [15:0]; RES[0] ignored.
  - lw: RES[1:0] ignored.
  - lb/lh: sign-extend; lbu/lhu: zero-extend.
- Write qualification: WR = V & RW & (DEST≠0) & (~LD | state==LOAD_DONE).
- RegFileWE = WR. RegFileWA = DEST. RegFileWD = LD ? LDATA : RES.
- ForwardRA = WR ? DEST : 0. ForwardRD = WR ? RegFileWD : 0. This prevents false forwarding on register 0.
- Non-load, non-writing instructions (stores, branches) pass through with WR=0.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): state=IDLE, V=0, all fields and LDATA=0. All outputs are 0 during reset and immediately after release.
- Reset mid-load aborts it. A DMemValid arriving after release is ignored.
- Non-load latency: the instruction captured at edge N writes and forwards during cycle N..N+1. RegFileWE is combinational from the stage register.
- Load latency:
  - Captured at edge N; Stall=1 from edge N.
  - If DMemValid=1 is sampled at edge N+1, the state is LOAD_DONE in cycle N+1. Write and forward occur then, and Stall drops.
  - Minimum one stall cycle; each additional cycle of DMemValid=0 adds one stall cycle.
- DMemValid is ignored outside LOAD_WAIT.
- Back-to-back loads: capture at the LOAD_DONE edge re-enters LOAD_WAIT. The first load's write completes in LOAD_DONE before capture.
- Kill while Stall=1 has no effect. Bubbles enter only on non-stalled edges.
- Killed load (Kill=1, MemRead=1): V=0; no FSM transition, no stall.
- Stall, RegFileWE/WA/WD, and ForwardRA/RD are glitch-free combinational functions of registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset mid-load:** issue lb, hold DMemValid=0 for 2 cycles, pulse rst_n=0 → all outputs 0. Stall stays 0 after release; a late DMemValid produces no write.
- **ALU write:** ALUResult=0x0000_1234, RegDest=8, RegWrite=1 → one cycle later RegFileWE=1, WA=8, WD=0x1234, ForwardRA=8, ForwardRD=0x1234.
- **Register-0 suppression:** RegDest=0, RegWrite=1, ALUResult=0xDEAD_BEEF → RegFileWE=0, ForwardRA=0, ForwardRD=0.
- **lb with wait states:** address 0x...01, DMemDout=0x11_F2_33_44, DMemValid after 3 cycles → Stall=1 for 3 cycles, then WD=0xFFFF_FFF2. The same case with lbu gives 0x0000_00F2.
- **lh/lw extraction:**
  - lh at RES[1:0]=2 with 0x1234_8765 → 0xFFFF_8765.
  - lhu at RES[1:0]=0 → 0x0000_1234.
  - lw at RES[1:0]=3 → 0x1234_8765.
- **Back-to-back loads:** two loads to $5 and $6, each with DMemValid one cycle after capture → writes on consecutive non-stall cycles with correct WA and WD; total Stall=2 cycles.
- **Kill during stall:** pulse Kill while Stall=1 → no state change. A Kill on the next free edge yields V=0 and no write.
